// File: rtl/avalon_bus_arbiter.sv
// ---------------------------------------------------------------------------
// avalon_bus_arbiter
//
// Shares one Avalon-MM slave port between two masters: m0 (instruction
// fetch) and m1 (data load/store). A grant is registered and held for the
// whole transaction until the slave drops s_waitrequest. A watchdog aborts
// a granted transaction that the slave never completes.
//
// Handshake (Avalon-MM, used identically on both master sides and the slave
// side): a master asserts read or write with address/data/byteenable and
// holds them stable while its waitrequest is high. The transfer completes
// in the cycle where the strobe is high and waitrequest is low. Read data
// is valid only in that completing cycle.
//
// Parameters:
//   TIMEOUT_CYCLES  consecutive granted wait cycles before abort (1..65535)
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN  when defined, ties from IDLE go to the master not
//                       granted last (first tie after reset goes to m0).
//                       When undefined, m1 always wins ties.
//
// Ports:
//   clk, reset                     clock, async active-low reset
//   m0_*/m1_* address, read, write, writedata, byteenable   master requests
//   m0_waitrequest, m1_waitrequest high = master holds its request
//   m0_readdata, m1_readdata       read data in the completing cycle
//   s_address, s_read, s_write, s_writedata, s_byteenable  to slave
//   s_waitrequest, s_readdata      from slave
//   bus_error                      sticky watchdog-abort flag
//   dbg_state                      current FSM state (0 IDLE, 1 GRANT0, 2 GRANT1)
// ---------------------------------------------------------------------------
module avalon_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  // master 0: instruction fetch
  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  // master 1: data load/store
  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  // slave
  output logic [31:0] s_address,
  output logic        s_read,
  output logic        s_write,
  output logic [31:0] s_writedata,
  output logic [3:0]  s_byteenable,
  input  logic        s_waitrequest,
  input  logic [31:0] s_readdata,
  // status
  output logic        bus_error,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT = 16'(TIMEOUT_CYCLES);

  state_t      state, state_nxt;
  logic [15:0] wd_cnt, wd_cnt_nxt;
  logic        err_q, err_nxt;

  logic        m0_req, m1_req;
  logic        granted;
  logic        gnt_req, gnt_read, gnt_write;
  logic [31:0] gnt_address, gnt_writedata;
  logic [3:0]  gnt_byteenable;
  logic        other_req;
  logic        abort;
  logic        complete;
  logic        tie_pick_m1;

  assign m0_req = m0_read | m0_write;
  assign m1_req = m1_read | m1_write;

  // -------------------------------------------------------------------------
  // Tie-break policy
  // -------------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
  // last_m1 = 1 means m1 held the most recent grant. It resets to m1 so the
  // first tie after reset goes to m0.
  logic last_m1, last_m1_nxt;

  always_comb begin
    last_m1_nxt = last_m1;
    if (state_nxt == ST_GRANT1) begin
      last_m1_nxt = 1'b1;
    end else if (state_nxt == ST_GRANT0) begin
      last_m1_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_m1 <= 1'b1;
    end else begin
      last_m1 <= last_m1_nxt;
    end
  end

  assign tie_pick_m1 = ~last_m1;
`else
  assign tie_pick_m1 = 1'b1;
`endif

  // -------------------------------------------------------------------------
  // Granted-master selection
  // -------------------------------------------------------------------------
  always_comb begin
    granted        = 1'b0;
    gnt_req        = 1'b0;
    gnt_read       = 1'b0;
    gnt_write      = 1'b0;
    gnt_address    = 32'h0;
    gnt_writedata  = 32'h0;
    gnt_byteenable = 4'h0;
    other_req      = 1'b0;
    case (state)
      ST_GRANT0: begin
        granted        = 1'b1;
        gnt_req        = m0_req;
        gnt_read       = m0_read;
        gnt_write      = m0_write;
        gnt_address    = m0_address;
        gnt_writedata  = m0_writedata;
        gnt_byteenable = m0_byteenable;
        other_req      = m1_req;
      end
      ST_GRANT1: begin
        granted        = 1'b1;
        gnt_req        = m1_req;
        gnt_read       = m1_read;
        gnt_write      = m1_write;
        gnt_address    = m1_address;
        gnt_writedata  = m1_writedata;
        gnt_byteenable = m1_byteenable;
        other_req      = m0_req;
      end
      default: begin
      end
    endcase
  end

  // Abort takes precedence over a late completion in the same cycle: once the
  // count has reached the limit the strobes are already forced low.
  assign abort    = granted & gnt_req & (wd_cnt == TIMEOUT);
  assign complete = granted & gnt_req & ~s_waitrequest & ~abort;

  // -------------------------------------------------------------------------
  // FSM next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (m0_req && m1_req) begin
          state_nxt = tie_pick_m1 ? ST_GRANT1 : ST_GRANT0;
        end else if (m1_req) begin
          state_nxt = ST_GRANT1;
        end else if (m0_req) begin
          state_nxt = ST_GRANT0;
        end
      end
      ST_GRANT0, ST_GRANT1: begin
        if (!gnt_req || abort) begin
          // A dropped request is a master protocol violation; it is tolerated
          // silently. Abort always returns to IDLE.
          state_nxt = ST_IDLE;
        end else if (complete) begin
          // Back-to-back hand-over avoids an idle bubble.
          if (other_req) begin
            state_nxt = (state == ST_GRANT0) ? ST_GRANT1 : ST_GRANT0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Watchdog counter and sticky error
  // -------------------------------------------------------------------------
  always_comb begin
    wd_cnt_nxt = wd_cnt;
    if (!granted || (state_nxt != state) || complete || abort) begin
      wd_cnt_nxt = 16'h0;
    end else if (s_waitrequest) begin
      wd_cnt_nxt = wd_cnt + 16'd1;
    end
  end

  assign err_nxt = err_q | abort;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      wd_cnt <= 16'h0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      wd_cnt <= wd_cnt_nxt;
      err_q  <= err_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    s_address      = 32'h0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = 32'h0;
    s_byteenable   = 4'h0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    m0_readdata    = 32'h0;
    m1_readdata    = 32'h0;
    if (granted) begin
      s_address    = gnt_address;
      s_writedata  = gnt_writedata;
      s_byteenable = gnt_byteenable;
      // Read+write together is illegal; the write is the one that goes out.
      s_write      = gnt_write & ~abort;
      s_read       = gnt_read & ~gnt_write & ~abort;
      if (state == ST_GRANT0) begin
        m0_waitrequest = ~(~s_waitrequest | abort);
        m0_readdata    = abort ? 32'h0 : s_readdata;
      end else begin
        m1_waitrequest = ~(~s_waitrequest | abort);
        m1_readdata    = abort ? 32'h0 : s_readdata;
      end
    end
  end

  // Include the abort cycle itself so the flag rises with the abort.
  assign bus_error = err_q | abort;
  assign dbg_state = state;

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_avalon_bus_arbiter
//
// Directed bench for avalon_bus_arbiter (TIMEOUT_CYCLES = 4). A simple slave
// model inserts a programmable number of wait cycles. Stimulus pushes the
// expected slave accesses and master completions into queues; a monitor on
// the falling edge pops and compares them as the DUT presents them.
// ---------------------------------------------------------------------------
module tb_avalon_bus_arbiter;

  logic        clk;
  logic        reset;
  logic [31:0] m0_address, m1_address;
  logic        m0_read, m1_read, m0_write, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic [31:0] s_address;
  logic        s_read, s_write;
  logic [31:0] s_writedata;
  logic [3:0]  s_byteenable;
  logic        s_waitrequest;
  logic [31:0] s_readdata;
  logic        bus_error;
  logic [1:0]  dbg_state;

  int n_vec;
  int n_err;

  // expected slave accesses: {write, address, writedata, byteenable}
  logic [68:0] exp_acc_q[$];
  // expected master completions: {bus_error, master, readdata}
  logic [33:0] exp_cpl_q[$];

  // slave model controls
  logic        slave_stuck;
  int          slave_waits;
  logic [31:0] slave_rdata;
  int          wcnt;

  avalon_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .m0_address    (m0_address),
    .m0_read       (m0_read),
    .m0_write      (m0_write),
    .m0_writedata  (m0_writedata),
    .m0_byteenable (m0_byteenable),
    .m0_waitrequest(m0_waitrequest),
    .m0_readdata   (m0_readdata),
    .m1_address    (m1_address),
    .m1_read       (m1_read),
    .m1_write      (m1_write),
    .m1_writedata  (m1_writedata),
    .m1_byteenable (m1_byteenable),
    .m1_waitrequest(m1_waitrequest),
    .m1_readdata   (m1_readdata),
    .s_address     (s_address),
    .s_read        (s_read),
    .s_write       (s_write),
    .s_writedata   (s_writedata),
    .s_byteenable  (s_byteenable),
    .s_waitrequest (s_waitrequest),
    .s_readdata    (s_readdata),
    .bus_error     (bus_error),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- slave model ----------------
  assign s_waitrequest = slave_stuck | ((s_read | s_write) && (wcnt < slave_waits));
  assign s_readdata    = slave_rdata;

  always @(posedge clk) begin
    if (!(s_read | s_write) || !s_waitrequest) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [68:0] acc(input logic wr, input logic [31:0] a,
                                      input logic [31:0] wd, input logic [3:0] be);
    return {wr, a, wd, be};
  endfunction

  function automatic logic [33:0] cpl(input logic err, input logic m, input logic [31:0] rd);
    return {err, m, rd};
  endfunction

  task automatic set_m(input logic m, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    if (m) begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = wd; m1_byteenable = be;
    end else begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = wd; m0_byteenable = be;
    end
  endtask

  task automatic clr_m(input logic m);
    set_m(m, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns at a falling edge where master m's waitrequest is low.
  task automatic wait_done(input logic m, input string name, input bit check_now);
    bit done;
    done = check_now && ((m ? m1_waitrequest : m0_waitrequest) == 1'b0);
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if ((m ? m1_waitrequest : m0_waitrequest) == 1'b0) done = 1'b1;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: waitrequest never low within budget", name);
    end
  endtask

  // Simultaneous m0 read and m1 request from IDLE; checks order and no bubble.
  task automatic run_tie(input int waits, input logic m1_wr, input logic [31:0] a0,
                         input logic [31:0] a1, input logic [31:0] wd1, input logic [3:0] be1,
                         input logic [31:0] rdata, input logic err);
    logic        first;
    logic [31:0] addr_second;
`ifdef ARB_ROUND_ROBIN_EN
    first = 1'b0;
`else
    first = 1'b1;
`endif
    slave_waits = waits;
    slave_rdata = rdata;
    set_m(1'b0, 1'b1, 1'b0, a0, 32'h0, 4'hF);
    set_m(1'b1, ~m1_wr, m1_wr, a1, wd1, be1);
    if (first) begin
      exp_acc_q.push_back(acc(m1_wr, a1, wd1, be1));
      exp_acc_q.push_back(acc(1'b0, a0, 32'h0, 4'hF));
      exp_cpl_q.push_back(cpl(err, 1'b1, rdata));
      exp_cpl_q.push_back(cpl(err, 1'b0, rdata));
      addr_second = a0;
    end else begin
      exp_acc_q.push_back(acc(1'b0, a0, 32'h0, 4'hF));
      exp_acc_q.push_back(acc(m1_wr, a1, wd1, be1));
      exp_cpl_q.push_back(cpl(err, 1'b0, rdata));
      exp_cpl_q.push_back(cpl(err, 1'b1, rdata));
      addr_second = a1;
    end
    wait_done(first, "tie_first_done", 1'b0);
    tick();
    clr_m(first);
    @(negedge clk);
    check("tie_no_bubble_addr", {32'h0, s_address}, {32'h0, addr_second});
    check("tie_no_bubble_strobe", s_read | s_write, 1'b1);
    wait_done(~first, "tie_second_done", 1'b1);
    tick();
    clr_m(~first);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (reset) begin
      if ((s_read || s_write) && !s_waitrequest) begin
        n_vec++;
        if (exp_acc_q.size() == 0) begin
          n_err++;
          $display("FAIL slave_access: unexpected access %h", acc(s_write, s_address, s_writedata, s_byteenable));
        end else begin
          logic [68:0] e;
          e = exp_acc_q.pop_front();
          if (acc(s_write, s_address, s_writedata, s_byteenable) !== e) begin
            n_err++;
            $display("FAIL slave_access: got %h expected %h",
                     acc(s_write, s_address, s_writedata, s_byteenable), e);
          end
        end
      end
      if (!m0_waitrequest || !m1_waitrequest) begin
        logic [33:0] a;
        a = !m1_waitrequest ? cpl(bus_error, 1'b1, m1_readdata) : cpl(bus_error, 1'b0, m0_readdata);
        n_vec++;
        if (!m0_waitrequest && !m1_waitrequest) begin
          n_err++;
          $display("FAIL completion: both waitrequests low");
        end else if (exp_cpl_q.size() == 0) begin
          n_err++;
          $display("FAIL completion: unexpected completion %h", a);
        end else begin
          logic [33:0] e;
          e = exp_cpl_q.pop_front();
          if (a !== e) begin
            n_err++;
            $display("FAIL completion: got %h expected %h", a, e);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    clr_m(1'b0);
    clr_m(1'b1);
    slave_stuck = 1'b0;
    slave_waits = 0;
    slave_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    check("rst_state", dbg_state, 2'd0);
    check("rst_strobes", {s_read, s_write}, 2'b00);
    check("rst_s_bus", {s_address, s_writedata}, 64'h0);
    check("rst_s_be", s_byteenable, 4'h0);
    check("rst_waitreq", {m0_waitrequest, m1_waitrequest}, 2'b11);
    check("rst_bus_error", bus_error, 1'b0);
    reset = 1'b1;
    tick();

    // simultaneous m0 read / m1 write, 2 wait cycles
    run_tie(2, 1'b1, 32'h0000_0100, 32'h0000_0200, 32'hCAFE_F00D, 4'b0011, 32'h5A5A_0001, 1'b0);
    tick();

    // single read, zero-wait slave
    slave_waits = 0;
    slave_rdata = 32'h1234_5678;
    set_m(1'b0, 1'b1, 1'b0, 32'hBFC0_0000, 32'h0, 4'hF);
    exp_acc_q.push_back(acc(1'b0, 32'hBFC0_0000, 32'h0, 4'hF));
    exp_cpl_q.push_back(cpl(1'b0, 1'b0, 32'h1234_5678));
    @(negedge clk);
    check("rd0_cycleN_s_read", s_read, 1'b0);
    check("rd0_cycleN_waitreq", m0_waitrequest, 1'b1);
    @(negedge clk);
    check("rd0_N1_s_read", s_read, 1'b1);
    check("rd0_N1_waitreq", m0_waitrequest, 1'b0);
    check("rd0_N1_readdata", m0_readdata, 32'h1234_5678);
    tick();
    clr_m(1'b0);
    tick();

    // m0 write held off for 3 slave wait cycles
    slave_waits = 3;
    slave_rdata = 32'h0;
    set_m(1'b0, 1'b0, 1'b1, 32'h3000_0040, 32'h0BAD_BEEF, 4'b1100);
    exp_acc_q.push_back(acc(1'b1, 32'h3000_0040, 32'h0BAD_BEEF, 4'b1100));
    exp_cpl_q.push_back(cpl(1'b0, 1'b0, 32'h0));
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_waitreq", m0_waitrequest, 1'b1);
      check("hold_s_bus", {s_address, s_writedata}, {32'h3000_0040, 32'h0BAD_BEEF});
      check("hold_s_ctrl", {s_write, s_read, s_byteenable}, {2'b10, 4'b1100});
    end
    wait_done(1'b0, "hold_done", 1'b0);
    tick();
    clr_m(1'b0);
    tick();

    // watchdog: slave stuck, TIMEOUT_CYCLES = 4
    slave_stuck = 1'b1;
    slave_rdata = 32'hDEAD_0000;
    set_m(1'b1, 1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'hF);
    exp_cpl_q.push_back(cpl(1'b1, 1'b1, 32'h0));
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("wd_wait_waitreq", m1_waitrequest, 1'b1);
      check("wd_wait_err", bus_error, 1'b0);
    end
    @(negedge clk);
    check("wd_abort_waitreq", m1_waitrequest, 1'b0);
    check("wd_abort_readdata", m1_readdata, 32'h0);
    check("wd_abort_s_read", s_read, 1'b0);
    check("wd_abort_err", bus_error, 1'b1);
    tick();
    clr_m(1'b1);
    slave_stuck = 1'b0;
    @(negedge clk);
    check("wd_after_state", dbg_state, 2'd0);
    check("wd_after_err", bus_error, 1'b1);
    // m0 request after abort is served normally
    slave_waits = 0;
    slave_rdata = 32'h0000_BEEF;
    tick();
    set_m(1'b0, 1'b1, 1'b0, 32'h0000_0080, 32'h0, 4'hF);
    exp_acc_q.push_back(acc(1'b0, 32'h0000_0080, 32'h0, 4'hF));
    exp_cpl_q.push_back(cpl(1'b1, 1'b0, 32'h0000_BEEF));
    wait_done(1'b0, "wd_next_done", 1'b0);
    tick();
    clr_m(1'b0);
    tick();

    // reset asserted during a GRANT1 wait
    slave_waits = 5;
    set_m(1'b1, 1'b0, 1'b1, 32'h0000_0500, 32'h1111_2222, 4'hF);
    @(negedge clk);
    @(negedge clk);
    check("rstmid_pre_s_write", s_write, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("rstmid_s_write", s_write, 1'b0);
    check("rstmid_waitreq", m1_waitrequest, 1'b1);
    check("rstmid_err_clear", bus_error, 1'b0);
    clr_m(1'b1);
    tick();
    reset = 1'b1;
    tick();
    run_tie(0, 1'b0, 32'h0000_0600, 32'h0000_0700, 32'h0, 4'hF, 32'h7777_0001, 1'b0);
    tick();
    tick();

    check("acc_queue_empty", exp_acc_q.size(), 0);
    check("cpl_queue_empty", exp_cpl_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
